status_bar_gen: RTL and testbench
=================================

Name: status_bar_gen

Overview:
- Owns the player's health and score state for the Dungeon Crawler HUD.
- Renders the health and score bars as per-pixel codes, which feed the colorizer's health_disp_ip and score_disp_ip inputs.
- Sits between the game-logic event sources (hero/monster collisions, treasure pickup) and the colorizer. It is driven by the display timing generator's row, column and frame signals.

Parameters:
HEALTH_MAX, 64, full health; legal range 4..127
SCORE_MAX, 255, score saturation value
BAR_X0, 16, left column of both bars
HBAR_Y0, 8, first row of health bar
SBAR_Y0, 20, first row of score bar
BAR_H, 8, bar height in rows
PIX_PER_UNIT, 2, columns drawn per health point (score: 1 column per point)
FLASH_FRAMES, 8, frames of hit-flash

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous, active-low reset
video_on  in  1  from DTG, high in the visible region
pixel_row  in  10  current row from DTG
pixel_column  in  10  current column from DTG
frame_tick  in  1  1-cycle pulse at start of vertical blank
hit  in  1  1-cycle damage event
hit_amt  in  4  damage amount
heal  in  1  1-cycle heal event
heal_amt  in  4  heal amount
treasure  in  1  1-cycle score event
treasure_amt  in  4  score increment
game_restart  in  1  1-cycle restart request
health_disp  out  2  00 none, 01 low, 10 mid, 11 full; to colorizer
score_disp  out  1  score-bar pixel; to colorizer
health  out  7  live health
score  out  8  live score
dead  out  1  high while in DEAD

Behaviour:
- Reset: clk and reset_n only; synchronous, active-low.
- Reset state: health=HEALTH_MAX, score=0, state ALIVE, displayed copies = reset values, health_disp=00, score_disp=0, dead=0, flash counter 0.

Health update (one cycle after event):
- Net delta = (heal?heal_amt:0) - (hit?hit_amt:0).
- Compute in 9-bit signed arithmetic, then saturate to 0..HEALTH_MAX.
- Simultaneous hit and heal apply once as a net change.

Score update:
- score += treasure_amt, saturating at SCORE_MAX.
- Treasure counts in ALIVE and HIT_FLASH; it is ignored in DEAD.

FSM:
- ALIVE:
  - hit with resulting health 0 -> DEAD.
  - Any other hit with hit_amt != 0 -> HIT_FLASH; the flash counter loads FLASH_FRAMES.
- HIT_FLASH:
  - Counter decrements on each frame_tick; reaches 0 -> ALIVE.
  - A new hit reloads the counter.
  - Health reaching 0 -> DEAD.
- DEAD:
  - dead=1; hit, heal and treasure are ignored.
  - game_restart -> ALIVE with health=HEALTH_MAX, score=0.
- game_restart in any state has the same effect as in DEAD and has priority over same-cycle events.

Display latching:
- Displayed health and score are copied from the live values only on frame_tick, so there is no tearing mid-frame.
- Level code from displayed health:
  - >= HEALTH_MAX/2 -> 11
  - >= HEALTH_MAX/4 -> 10
  - > 0 -> 01
  - 0 -> 00

Pixel output (registered, 1-cycle latency from row/column):
- health_disp = level code when all of the following hold; otherwise 00:
  - video_on=1
  - row in [HBAR_Y0, HBAR_Y0+BAR_H)
  - column in [BAR_X0, BAR_X0 + disp_health*PIX_PER_UNIT)
- Health-bar blanking: health_disp is also forced to 00 in DEAD, and in HIT_FLASH when flash counter bit0 = 1.
- score_disp = 1 when all of the following hold; otherwise 0:
  - video_on=1
  - row in [SBAR_Y0, SBAR_Y0+BAR_H)
  - column in [BAR_X0, BAR_X0 + disp_score)
- Column compares are 11-bit so no wrap occurs.

Optional Feature:
- Macro: STATUS_HIT_FLASH_EN.
- Defined: HIT_FLASH state and flash counter exist as described.
- Undefined: a non-lethal hit leaves the state in ALIVE, the flash counter is removed, and the health bar never blanks except in DEAD.

Decomposition:
- Package status_pkg:
  - state enum (ST_ALIVE, ST_HIT_FLASH, ST_DEAD)
  - health level codes (HB_NONE=2'b00, HB_LOW=2'b01, HB_MID=2'b10, HB_FULL=2'b11)
  - widths for health, score and coordinates
- Sub-module bar_hit: combinational test of row/column against rectangle origin, height and length. Instantiated twice, once for the health bar and once for the score bar.

Test Plan:
- Reset, then frame_tick. Row 8: health_disp=11 for columns 16..143 and 00 at column 144. Row 16: 00. video_on=0: 00 everywhere.
- hit_amt=10 three times -> health=34, still 11. hit_amt=5 -> 29; health_disp stays 11 until the next frame_tick, then 10. At 15 the code becomes 01.
- At health 60, simultaneous hit 4 and heal 6 -> 62. At 64 the same pair -> 64 (saturated).
- At health 3, hit 15 -> health 0, dead=1, health bar 00. Subsequent heal and treasure have no effect. game_restart -> health 64, score 0, dead=0.
- treasure_amt=15 applied 20 times -> score=255 (saturated). After frame_tick, score_disp=1 on row 20 for columns 16..270 and 0 at column 271.
- STATUS_HIT_FLASH_EN defined: hit 1 at health 64 -> the health bar blanks on alternate frames for 8 frame_ticks, then is steady 11. A second hit mid-flash restarts the 8-frame count.

Source files
------------

// File: rtl/status_bar_gen_pkg.sv
// Shared types and constants for the Dungeon Crawler HUD status bars.
package status_pkg;

    typedef enum logic [1:0] {
        ST_ALIVE     = 2'd0,
        ST_HIT_FLASH = 2'd1,
        ST_DEAD      = 2'd2
    } state_e;

    localparam logic [1:0] HB_NONE = 2'b00;
    localparam logic [1:0] HB_LOW  = 2'b01;
    localparam logic [1:0] HB_MID  = 2'b10;
    localparam logic [1:0] HB_FULL = 2'b11;

    localparam int HEALTH_W = 7;
    localparam int SCORE_W  = 8;
    localparam int AMT_W    = 4;
    localparam int COORD_W  = 10;
    localparam int CMP_W    = 11;

    // Bar colour band chosen from the displayed health relative to full health.
    function automatic logic [1:0] level_code(input logic [HEALTH_W-1:0] h, input int hmax);
        int hv;
        hv = int'(h);
        if (hv >= hmax / 2)      return HB_FULL;
        else if (hv >= hmax / 4) return HB_MID;
        else if (hv > 0)         return HB_LOW;
        else                     return HB_NONE;
    endfunction

endpackage

// File: rtl/status_bar_gen_if.sv
// Bus between the game-logic/display-timing sources and the status bar generator.
interface status_bar_if;
    import status_pkg::*;

    logic                video_on;
    logic [COORD_W-1:0]  pixel_row;
    logic [COORD_W-1:0]  pixel_column;
    logic                frame_tick;
    logic                hit;
    logic [AMT_W-1:0]    hit_amt;
    logic                heal;
    logic [AMT_W-1:0]    heal_amt;
    logic                treasure;
    logic [AMT_W-1:0]    treasure_amt;
    logic                game_restart;
    logic [1:0]          health_disp;
    logic                score_disp;
    logic [HEALTH_W-1:0] health;
    logic [SCORE_W-1:0]  score;
    logic                dead;

    modport master (
        output video_on, pixel_row, pixel_column, frame_tick,
        output hit, hit_amt, heal, heal_amt, treasure, treasure_amt, game_restart,
        input  health_disp, score_disp, health, score, dead
    );

    modport slave (
        input  video_on, pixel_row, pixel_column, frame_tick,
        input  hit, hit_amt, heal, heal_amt, treasure, treasure_amt, game_restart,
        output health_disp, score_disp, health, score, dead
    );

endinterface

// File: rtl/status_bar_gen_bar_hit.sv
// Combinational test of a pixel position against a bar rectangle.
module bar_hit
    import status_pkg::*;
(
    input  logic [COORD_W-1:0] row_i,
    input  logic [COORD_W-1:0] col_i,
    input  logic [CMP_W-1:0]   x0_i,
    input  logic [CMP_W-1:0]   y0_i,
    input  logic [CMP_W-1:0]   height_i,
    input  logic [CMP_W-1:0]   len_i,
    output logic               hit_o
);

    logic [CMP_W-1:0] row;
    logic [CMP_W-1:0] col;

    // One extra bit so origin + extent never wraps.
    assign row   = {1'b0, row_i};
    assign col   = {1'b0, col_i};
    assign hit_o = (row >= y0_i) && (row < y0_i + height_i) &&
                   (col >= x0_i) && (col < x0_i + len_i);

endmodule

// File: rtl/status_bar_gen.sv
// HUD health/score state and per-pixel bar rendering.
// Optional hit-flash blanking of the health bar is enabled by STATUS_HIT_FLASH_EN.
module status_bar_gen
    import status_pkg::*;
#(
    parameter int HEALTH_MAX   = 64,
    parameter int SCORE_MAX    = 255,
    parameter int BAR_X0       = 16,
    parameter int HBAR_Y0      = 8,
    parameter int SBAR_Y0      = 20,
    parameter int BAR_H        = 8,
    parameter int PIX_PER_UNIT = 2
`ifdef STATUS_HIT_FLASH_EN
    , parameter int FLASH_FRAMES = 8
`endif
) (
    input  logic clk,
    input  logic reset_n,
    status_bar_if.slave bus
);

    localparam logic [HEALTH_W-1:0] HMAX_C  = HEALTH_W'(HEALTH_MAX);
    localparam logic signed [8:0]   HMAX_S  = 9'(HEALTH_MAX);
    localparam logic [SCORE_W-1:0]  SMAX_C  = SCORE_W'(SCORE_MAX);
    localparam logic [8:0]          SMAX_9  = 9'(SCORE_MAX);
    localparam logic [CMP_W-1:0]    X0_C    = CMP_W'(BAR_X0);
    localparam logic [CMP_W-1:0]    HY0_C   = CMP_W'(HBAR_Y0);
    localparam logic [CMP_W-1:0]    SY0_C   = CMP_W'(SBAR_Y0);
    localparam logic [CMP_W-1:0]    BH_C    = CMP_W'(BAR_H);
    localparam logic [CMP_W-1:0]    PPU_C   = CMP_W'(PIX_PER_UNIT);

    state_e              state_q, state_d;
    logic [HEALTH_W-1:0] health_q, health_d;
    logic [SCORE_W-1:0]  score_q, score_d;
    logic [HEALTH_W-1:0] dispHealth_q;
    logic [SCORE_W-1:0]  dispScore_q;
    logic [1:0]          healthDisp_q;
    logic                scoreDisp_q;

    logic [8:0]          healExt, hitExt;
    logic signed [8:0]   healthSum;
    logic [HEALTH_W-1:0] newHealth;
    logic [8:0]          scoreSum;
    logic [SCORE_W-1:0]  newScore;
    logic                healthBlank;
    logic                inHealthBar, inScoreBar;

`ifdef STATUS_HIT_FLASH_EN
    localparam int FLASH_W = $clog2(FLASH_FRAMES + 1);
    localparam logic [FLASH_W-1:0] FLASH_C = FLASH_W'(FLASH_FRAMES);
    logic [FLASH_W-1:0] flash_q, flash_d;
`endif

    // Heal and hit combine into one signed delta, then clamp to 0..HEALTH_MAX.
    assign healExt   = bus.heal ? 9'(bus.heal_amt) : 9'd0;
    assign hitExt    = bus.hit  ? 9'(bus.hit_amt)  : 9'd0;
    assign healthSum = $signed({2'b00, health_q}) + $signed(healExt) - $signed(hitExt);
    assign scoreSum  = {1'b0, score_q} + 9'(bus.treasure_amt);
    assign newScore  = (scoreSum > SMAX_9) ? SMAX_C : scoreSum[SCORE_W-1:0];

    always_comb begin
        newHealth = healthSum[HEALTH_W-1:0];
        if (healthSum[8])
            newHealth = '0;
        else if (healthSum > HMAX_S)
            newHealth = HMAX_C;
    end

    always_comb begin
        state_d  = state_q;
        health_d = health_q;
        score_d  = score_q;
`ifdef STATUS_HIT_FLASH_EN
        flash_d  = flash_q;
`endif
        if (bus.game_restart) begin
            state_d  = ST_ALIVE;
            health_d = HMAX_C;
            score_d  = '0;
`ifdef STATUS_HIT_FLASH_EN
            flash_d  = '0;
`endif
        end else if (state_q != ST_DEAD) begin
            health_d = newHealth;
            if (bus.treasure)
                score_d = newScore;
            if (newHealth == '0) begin
                state_d = ST_DEAD;
`ifdef STATUS_HIT_FLASH_EN
                flash_d = '0;
            end else if (bus.hit && (bus.hit_amt != '0)) begin
                state_d = ST_HIT_FLASH;
                flash_d = FLASH_C;
            end else if ((state_q == ST_HIT_FLASH) && bus.frame_tick) begin
                flash_d = flash_q - FLASH_W'(1);
                if (flash_q == FLASH_W'(1))
                    state_d = ST_ALIVE;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= ST_ALIVE;
            health_q <= HMAX_C;
            score_q  <= '0;
`ifdef STATUS_HIT_FLASH_EN
            flash_q  <= '0;
`endif
        end else begin
            state_q  <= state_d;
            health_q <= health_d;
            score_q  <= score_d;
`ifdef STATUS_HIT_FLASH_EN
            flash_q  <= flash_d;
`endif
        end
    end

`ifdef STATUS_HIT_FLASH_EN
    assign healthBlank = (state_q == ST_DEAD) || ((state_q == ST_HIT_FLASH) && flash_q[0]);
`else
    assign healthBlank = (state_q == ST_DEAD);
`endif

    bar_hit u_health_bar (
        .row_i    (bus.pixel_row),
        .col_i    (bus.pixel_column),
        .x0_i     (X0_C),
        .y0_i     (HY0_C),
        .height_i (BH_C),
        .len_i    (CMP_W'(dispHealth_q) * PPU_C),
        .hit_o    (inHealthBar)
    );

    bar_hit u_score_bar (
        .row_i    (bus.pixel_row),
        .col_i    (bus.pixel_column),
        .x0_i     (X0_C),
        .y0_i     (SY0_C),
        .height_i (BH_C),
        .len_i    (CMP_W'(dispScore_q)),
        .hit_o    (inScoreBar)
    );

    // Displayed copies change only at frame start so a bar never tears mid-frame.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            dispHealth_q <= HMAX_C;
            dispScore_q  <= '0;
            healthDisp_q <= HB_NONE;
            scoreDisp_q  <= 1'b0;
        end else begin
            if (bus.frame_tick) begin
                dispHealth_q <= health_q;
                dispScore_q  <= score_q;
            end
            healthDisp_q <= (bus.video_on && inHealthBar && !healthBlank) ?
                            level_code(dispHealth_q, HEALTH_MAX) : HB_NONE;
            scoreDisp_q  <= bus.video_on && inScoreBar;
        end
    end

    assign bus.health_disp = healthDisp_q;
    assign bus.score_disp  = scoreDisp_q;
    assign bus.health      = health_q;
    assign bus.score       = score_q;
    assign bus.dead        = (state_q == ST_DEAD);

endmodule

// File: tb/tb_status_bar_gen.sv
// Self-checking bench for status_bar_gen: constant vectors, hand sequences and random
// traffic against a behavioural model; the flash sequence runs when STATUS_HIT_FLASH_EN is set.
module tb_status_bar_gen;
    import status_pkg::*;

    localparam int HMAX = 64;
    localparam int SMAX = 255;
    localparam int X0   = 16;
    localparam int HY0  = 8;
    localparam int SY0  = 20;
    localparam int BH   = 8;
    localparam int PPU  = 2;
    localparam int FF   = 8;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    status_bar_if bus();

    status_bar_gen dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        bit vid;
        int row;
        int col;
        int expHd;
        int expSd;
    } vec_t;

    int compared = 0;
    int mismatched = 0;

    // Behavioural model of the HUD state.
    int mH, mS, mDead, mFlash, mDH, mDS;
    int eHd, eSd;

    task automatic checkOutput(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int levelOf(input int h);
        if (h >= HMAX / 2) return 3;
        if (h >= HMAX / 4) return 2;
        if (h > 0)         return 1;
        return 0;
    endfunction

    function automatic int expHealthPix();
        int r, c;
        r = int'(bus.pixel_row);
        c = int'(bus.pixel_column);
        if (!bus.video_on || mDead != 0 || (mFlash % 2) == 1) return 0;
        if (r < HY0 || r >= HY0 + BH) return 0;
        if (c < X0 || c >= X0 + mDH * PPU) return 0;
        return levelOf(mDH);
    endfunction

    function automatic int expScorePix();
        int r, c;
        r = int'(bus.pixel_row);
        c = int'(bus.pixel_column);
        if (!bus.video_on) return 0;
        if (r < SY0 || r >= SY0 + BH) return 0;
        if (c < X0 || c >= X0 + mDS) return 0;
        return 1;
    endfunction

    task automatic modelReset();
        mH = HMAX; mS = 0; mDead = 0; mFlash = 0; mDH = HMAX; mDS = 0;
        eHd = 0; eSd = 0;
    endtask

    task automatic modelStep();
        int nh;
        int oldH;
        int oldS;
        oldH = mH;
        oldS = mS;
        if (bus.game_restart) begin
            mH = HMAX; mS = 0; mDead = 0; mFlash = 0;
        end else if (mDead == 0) begin
            nh = mH + (bus.heal ? int'(bus.heal_amt) : 0) - (bus.hit ? int'(bus.hit_amt) : 0);
            if (nh < 0) nh = 0;
            if (nh > HMAX) nh = HMAX;
            if (bus.treasure) mS = (mS + int'(bus.treasure_amt) > SMAX) ? SMAX : mS + int'(bus.treasure_amt);
            if (nh == 0) begin
                mDead = 1;
                mFlash = 0;
            end
`ifdef STATUS_HIT_FLASH_EN
            else if (bus.hit && bus.hit_amt != 0) mFlash = FF;
            else if (mFlash > 0 && bus.frame_tick) mFlash--;
`endif
            mH = nh;
        end
        if (bus.frame_tick) begin
            mDH = oldH;
            mDS = oldS;
        end
    endtask

    // Drive one cycle of inputs at the falling edge; returns at the next falling edge.
    task automatic applyStimulus(input bit hit, input int hitAmt, input bit heal, input int healAmt,
                                 input bit tre, input int treAmt, input bit restart, input bit ft,
                                 input bit vid, input int row, input int col);
        bus.hit = hit;           bus.hit_amt = 4'(hitAmt);
        bus.heal = heal;         bus.heal_amt = 4'(healAmt);
        bus.treasure = tre;      bus.treasure_amt = 4'(treAmt);
        bus.game_restart = restart;
        bus.frame_tick = ft;
        bus.video_on = vid;
        bus.pixel_row = 10'(row);
        bus.pixel_column = 10'(col);
        eHd = expHealthPix();
        eSd = expScorePix();
        modelStep();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic ev(input bit hit, input int hitAmt, input bit heal, input int healAmt,
                      input bit tre, input int treAmt, input bit restart);
        applyStimulus(hit, hitAmt, heal, healAmt, tre, treAmt, restart, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic frameTick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1'b1, 1'b0, 0, 0);
    endtask

    task automatic pix(input bit vid, input int row, input int col);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1'b0, vid, row, col);
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, "/health"}, int'(bus.health), mH);
        checkOutput({tag, "/score"}, int'(bus.score), mS);
        checkOutput({tag, "/dead"}, int'(bus.dead), mDead);
        checkOutput({tag, "/health_disp"}, int'(bus.health_disp), eHd);
        checkOutput({tag, "/score_disp"}, int'(bus.score_disp), eSd);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t hvec[$];
        vec_t svec[$];
        hvec.push_back('{1'b1,  8,  16, 3, 0});
        hvec.push_back('{1'b1,  8,  80, 3, 0});
        hvec.push_back('{1'b1,  8, 143, 3, 0});
        hvec.push_back('{1'b1,  8, 144, 0, 0});
        hvec.push_back('{1'b1,  8,  15, 0, 0});
        hvec.push_back('{1'b1, 15, 100, 3, 0});
        hvec.push_back('{1'b1, 16,  16, 0, 0});
        hvec.push_back('{1'b1,  7,  16, 0, 0});
        hvec.push_back('{1'b0,  8,  20, 0, 0});
        hvec.push_back('{1'b1, 20,  16, 0, 0});
        svec.push_back('{1'b1, 20,  16, 0, 1});
        svec.push_back('{1'b1, 20, 270, 0, 1});
        svec.push_back('{1'b1, 20, 271, 0, 0});
        svec.push_back('{1'b1, 20,  15, 0, 0});
        svec.push_back('{1'b1, 27, 100, 0, 1});
        svec.push_back('{1'b1, 28, 100, 0, 0});
        svec.push_back('{1'b0, 20, 100, 0, 0});

        bus.video_on = 0; bus.pixel_row = 0; bus.pixel_column = 0; bus.frame_tick = 0;
        bus.hit = 0; bus.hit_amt = 0; bus.heal = 0; bus.heal_amt = 0;
        bus.treasure = 0; bus.treasure_amt = 0; bus.game_restart = 0;
        modelReset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        checkOutput("reset/health", int'(bus.health), 64);
        checkOutput("reset/score", int'(bus.score), 0);
        checkOutput("reset/dead", int'(bus.dead), 0);
        checkOutput("reset/health_disp", int'(bus.health_disp), 0);
        checkOutput("reset/score_disp", int'(bus.score_disp), 0);

        frameTick();
        foreach (hvec[i]) begin
            pix(hvec[i].vid, hvec[i].row, hvec[i].col);
            checkOutput($sformatf("hvec%0d/health_disp", i), int'(bus.health_disp), hvec[i].expHd);
            checkOutput($sformatf("hvec%0d/score_disp", i), int'(bus.score_disp), hvec[i].expSd);
        end

        // Damage and display latching.
        repeat (3) ev(1, 10, 0, 0, 0, 0, 0);
        checkOutput("hit30/health", int'(bus.health), 34);
        frameTick();
        pix(1, 8, 16);
        checkAll("lvl34");
`ifndef STATUS_HIT_FLASH_EN
        checkOutput("lvl34/code", int'(bus.health_disp), 3);
`endif
        ev(1, 5, 0, 0, 0, 0, 0);
        checkOutput("hit5/health", int'(bus.health), 29);
        pix(1, 8, 16);
        checkAll("lvl29pre");
`ifndef STATUS_HIT_FLASH_EN
        checkOutput("lvl29pre/code", int'(bus.health_disp), 3);
`endif
        frameTick();
        pix(1, 8, 16);
        checkAll("lvl29");
`ifndef STATUS_HIT_FLASH_EN
        checkOutput("lvl29/code", int'(bus.health_disp), 2);
`endif
        ev(1, 14, 0, 0, 0, 0, 0);
        checkOutput("hit14/health", int'(bus.health), 15);
        frameTick();
        pix(1, 8, 16);
        checkAll("lvl15");
`ifndef STATUS_HIT_FLASH_EN
        checkOutput("lvl15/code", int'(bus.health_disp), 1);
`endif

        // Simultaneous hit and heal, including upper saturation.
        ev(0, 0, 0, 0, 0, 0, 1);
        ev(1, 4, 0, 0, 0, 0, 0);
        checkOutput("net/at60", int'(bus.health), 60);
        ev(1, 4, 1, 6, 0, 0, 0);
        checkOutput("net/62", int'(bus.health), 62);
        ev(0, 0, 0, 0, 0, 0, 1);
        ev(1, 4, 1, 6, 0, 0, 0);
        checkOutput("net/sat64", int'(bus.health), 64);

        // Death, ignored events, restart.
        ev(0, 0, 0, 0, 0, 0, 1);
        repeat (4) ev(1, 15, 0, 0, 0, 0, 0);
        ev(1, 1, 0, 0, 0, 0, 0);
        checkOutput("dead/at3", int'(bus.health), 3);
        ev(1, 15, 0, 0, 0, 0, 0);
        checkOutput("dead/health", int'(bus.health), 0);
        checkOutput("dead/dead", int'(bus.dead), 1);
        frameTick();
        pix(1, 8, 16);
        checkOutput("dead/health_disp", int'(bus.health_disp), 0);
        ev(0, 0, 1, 5, 1, 5, 0);
        checkOutput("dead/heal_ignored", int'(bus.health), 0);
        checkOutput("dead/treasure_ignored", int'(bus.score), 0);
        ev(0, 0, 0, 0, 0, 0, 1);
        checkOutput("restart/health", int'(bus.health), 64);
        checkOutput("restart/score", int'(bus.score), 0);
        checkOutput("restart/dead", int'(bus.dead), 0);

        // Score saturation and score bar extent.
        repeat (20) ev(0, 0, 0, 0, 1, 15, 0);
        checkOutput("score/sat", int'(bus.score), 255);
        frameTick();
        foreach (svec[i]) begin
            pix(svec[i].vid, svec[i].row, svec[i].col);
            checkOutput($sformatf("svec%0d/score_disp", i), int'(bus.score_disp), svec[i].expSd);
            checkOutput($sformatf("svec%0d/health_disp", i), int'(bus.health_disp), svec[i].expHd);
        end

`ifdef STATUS_HIT_FLASH_EN
        // Blink on odd counter values for eight frames, then steady.
        ev(0, 0, 0, 0, 0, 0, 1);
        frameTick();
        ev(1, 1, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 10; k++) begin
            frameTick();
            pix(1, 8, 16);
            checkOutput($sformatf("flash%0d", k), int'(bus.health_disp), (k < FF && (k % 2) == 1) ? 0 : 3);
        end
        ev(1, 1, 0, 0, 0, 0, 0);
        repeat (3) frameTick();
        ev(1, 1, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 9; k++) begin
            frameTick();
            pix(1, 8, 16);
            checkOutput($sformatf("reflash%0d", k), int'(bus.health_disp), (k < FF && (k % 2) == 1) ? 0 : 3);
        end
`endif

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            applyStimulus(($urandom_range(0, 7) == 0), int'($urandom_range(0, 15)),
                          ($urandom_range(0, 7) == 0), int'($urandom_range(0, 15)),
                          ($urandom_range(0, 5) == 0), int'($urandom_range(0, 15)),
                          ($urandom_range(0, 199) == 0), ($urandom_range(0, 9) == 0),
                          ($urandom_range(0, 7) != 0), int'($urandom_range(0, 31)),
                          int'($urandom_range(0, 290)));
            checkAll($sformatf("rnd%0d", n));
        end

        // Reset in the middle of activity wins over events.
        bus.treasure = 1; bus.treasure_amt = 4'd9; bus.hit = 1; bus.hit_amt = 4'd3;
        reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        bus.treasure = 0; bus.hit = 0;
        modelReset();
        checkOutput("rst2/health", int'(bus.health), 64);
        checkOutput("rst2/score", int'(bus.score), 0);
        checkOutput("rst2/dead", int'(bus.dead), 0);
        checkOutput("rst2/health_disp", int'(bus.health_disp), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
